deser_rr_arbiter: RTL and testbench
===================================

Name: deser_rr_arbiter

Overview:
- Shares one 16-bit serial deserializer between N_SRC serial sources.
- Grants the serial path to one requester per frame using round-robin order, and muxes that source's data and valid onto the deserializer input.
- Tags each completed frame with the source index.
- Detects stalled frames, then aborts and flushes the deserializer.

Parameters:
- N_SRC, 4: number of serial requesters (2..16).
- FRAME_LEN, 16: valid bits per frame. Must match the deserializer word width.
- TIMEOUT, 64: consecutive granted cycles without valid before an abort (>=2).
- ID_W, $clog2(N_SRC): width of the source id.

Ports:
- clk_i, input, 1: single clock.
- srst_i, input, 1: synchronous active-high reset.
- req_i, input, N_SRC: per-source frame request, level.
- data_i, input, N_SRC: per-source serial data bit.
- data_val_i, input, N_SRC: per-source serial bit valid.
- gnt_o, output, N_SRC: one-hot grant, registered.
- ser_data_o, output, 1: to deserializer data_i.
- ser_data_val_o, output, 1: to deserializer data_val_i.
- deser_srst_o, output, 1: to deserializer srst_i.
- frame_id_o, output, ID_W: index of the granted or last-granted source.
- frame_done_o, output, 1: one-cycle pulse when a frame completes.
- abort_o, output, 1: one-cycle pulse when a frame times out.

Behaviour:
- Reset (srst_i=1): state IDLE; gnt_o=0, frame_id_o=0, frame_done_o=0, abort_o=0; bit and idle counters 0; RR pointer last=N_SRC-1, so source 0 has top priority first.
- deser_srst_o = srst_i OR abort flush pulse. It is combinational in srst_i and registered in the flush pulse.
- FSM has two states: IDLE and ACTIVE.
- IDLE:
  - If any req_i bit is set, pick the first set bit searching last+1, last+2, ... modulo N_SRC.
  - Next cycle: gnt_o is one-hot on the winner, frame_id_o is the winner index, last is the winner, state is ACTIVE, counters are 0.
  - If no request, stay in IDLE.
- Request-to-grant latency is 1 cycle.
- ACTIVE, mux path (combinational):
  - ser_data_o = data_i[frame_id_o].
  - ser_data_val_o = data_val_i[frame_id_o].
  - Outside ACTIVE, both are 0.
  - data_val_i from non-granted sources is ignored.
- ACTIVE, per cycle:
  - Valid bit accepted: bit_cnt increments and idle_cnt clears.
  - No valid bit: idle_cnt increments.
- Frame completion:
  - When a valid bit is accepted with bit_cnt==FRAME_LEN-1, the next cycle has state IDLE, gnt_o=0, frame_done_o=1, bit_cnt=0.
  - frame_done_o therefore coincides with the deserializer's output-valid cycle.
  - frame_id_o is held through that cycle and until the next grant.
- Timeout:
  - When idle_cnt reaches TIMEOUT-1 and no valid bit arrives that cycle, the next cycle has state IDLE, gnt_o=0, abort_o=1, deser_srst_o=1 for exactly 1 cycle, counters 0.
  - The partial word is discarded. frame_done_o is not asserted.
  - last still advances past the aborted source.
- Grant spacing:
  - Minimum of 1 cycle with gnt_o=0 between consecutive frames.
  - A new grant can first appear 2 cycles after the final bit.
- req_i dropping mid-frame has no effect; the grant is held until completion or timeout.
- req_i is sampled only in IDLE.
- If the final bit arrives on the same cycle the timeout would fire, completion wins and abort_o stays 0.
- srst_i in ACTIVE:
  - Next cycle is IDLE with reset values.
  - deser_srst_o follows srst_i in the same cycle, so the deserializer also clears.
  - No frame_done_o or abort_o pulse.
- Invariants:
  - gnt_o is always one-hot or zero.
  - frame_done_o and abort_o are never asserted together.

Test Plan:
1. Reset, then req_i=4'b0001, source 0 sends 16 valid bits of 16'hA5C3 (MSB first) → gnt_o=4'b0001 one cycle after req; frame_done_o pulses the cycle after bit 16 with frame_id_o=0; deserializer word = 16'hA5C3.
2. req_i=4'b1111 held, every source streams continuously → grants in order 0,1,2,3,0; each gnt_o low for ≥1 cycle between frames; 5 frame_done_o pulses with ids 0,1,2,3,0.
3. req_i=4'b0110 with last=1 → source 2 granted first, then source 1; data_val_i toggling on sources 0 and 3 never reaches ser_data_val_o.
4. Source 1 granted, sends 5 bits, then valid low for 64 cycles → abort_o=1 and deser_srst_o=1 for one cycle; gnt_o=0; no frame_done_o; next grant goes to source 2 if it is requesting.
5. 16th valid bit lands on the 64th stall-counting cycle → frame_done_o=1, abort_o=0.
6. srst_i asserted after 8 bits of a frame → next cycle gnt_o=0, deser_srst_o=1 during the reset, no pulses; after release with req_i=4'b1000, source 0 is not granted and source 3 is granted 1 cycle later.

Source files
------------

// File: rtl/deser_rr_arbiter.sv
// Round-robin arbiter that lends one 16-bit serial deserializer to N_SRC serial sources,
// one frame at a time, with frame tagging and stall timeout/flush.
module deser_rr_arbiter #(
    parameter int N_SRC     = 4,
    parameter int FRAME_LEN = 16,
    parameter int TIMEOUT   = 64,
    parameter int ID_W      = $clog2(N_SRC)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [N_SRC-1:0] req_i,
    input  logic [N_SRC-1:0] data_i,
    input  logic [N_SRC-1:0] data_val_i,
    output logic [N_SRC-1:0] gnt_o,
    output logic             ser_data_o,
    output logic             ser_data_val_o,
    output logic             deser_srst_o,
    output logic [ID_W-1:0]  frame_id_o,
    output logic             frame_done_o,
    output logic             abort_o
);

    localparam int BIT_W  = $clog2(FRAME_LEN) + 1;
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t              state_q, state_d;
    logic [N_SRC-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;

    logic                found;
    logic [ID_W-1:0]     winner;
    logic [ID_W-1:0]     cand;
    logic                active;

    // Search starts one past the previous winner, so the last-served source ranks lowest.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = ID_W'((int'(last_q) + k) % N_SRC);
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign active         = (state_q == ACTIVE);
    assign ser_data_o     = active & data_i[id_q];
    assign ser_data_val_o = active & data_val_i[id_q];

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        gnt_d      = gnt_q;
        id_d       = id_q;
        last_d     = last_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d         = ACTIVE;
                    gnt_d[winner]   = 1'b1;
                    id_d            = winner;
                    last_d          = winner;
                    bit_cnt_d       = '0;
                    idle_cnt_d      = '0;
                end
            end
            ACTIVE: begin
                // A valid bit always beats the timeout, so a final bit on the last stall cycle completes.
                if (ser_data_val_o) begin
                    idle_cnt_d = '0;
                    if (bit_cnt_q == BIT_W'(FRAME_LEN - 1)) begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    abort_d    = 1'b1;
                    bit_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
        if (srst_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            id_q       <= '0;
            last_q     <= ID_W'(N_SRC - 1);
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            id_q       <= id_d;
            last_q     <= last_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    // The abort pulse doubles as the registered flush; srst_i passes straight through.
    assign deser_srst_o = srst_i | abort_q;
    assign gnt_o        = gnt_q;
    assign frame_id_o   = id_q;
    assign frame_done_o = done_q;
    assign abort_o      = abort_q;

endmodule

// File: tb/tb_deser_rr_arbiter.sv
// Randomized scoreboard bench for deser_rr_arbiter: stimulus predicts each frame outcome,
// a negedge monitor pops predictions on frame_done_o/abort_o and checks a bench-side deserializer.
module tb_deser_rr_arbiter;

    localparam int N       = 4;
    localparam int FLEN    = 16;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    logic           clk_i;
    logic           srst_i;
    logic [N-1:0]   req_i;
    logic [N-1:0]   data_i;
    logic [N-1:0]   data_val_i;
    logic [N-1:0]   gnt_o;
    logic           ser_data_o;
    logic           ser_data_val_o;
    logic           deser_srst_o;
    logic [IDW-1:0] frame_id_o;
    logic           frame_done_o;
    logic           abort_o;

    deser_rr_arbiter #(
        .N_SRC    (N),
        .FRAME_LEN(FLEN),
        .TIMEOUT  (TIMEOUT),
        .ID_W     (IDW)
    ) dut (
        .clk_i         (clk_i),
        .srst_i        (srst_i),
        .req_i         (req_i),
        .data_i        (data_i),
        .data_val_i    (data_val_i),
        .gnt_o         (gnt_o),
        .ser_data_o    (ser_data_o),
        .ser_data_val_o(ser_data_val_o),
        .deser_srst_o  (deser_srst_o),
        .frame_id_o    (frame_id_o),
        .frame_done_o  (frame_done_o),
        .abort_o       (abort_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_abort;
        int          id;
        logic [15:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_last = N - 1;

    // Bench-side model of the shared deserializer.
    logic [15:0] dsr   = '0;
    int          dcnt  = 0;
    logic [15:0] dword = '0;
    bit          drdy  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (((req >> ((last + k) % N)) & N'(1)) != '0) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] rand_req();
        return N'($urandom_range(1, (1 << N) - 1));
    endfunction

    // Monitor and deserializer model: inputs and DUT state are stable at the negedge,
    // so the model update here mirrors what the real deserializer does at the next posedge.
    always @(negedge clk_i) begin
        exp_t e;
        check("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);
        if (frame_done_o || abort_o) begin
            if (exp_q.size() == 0) begin
                check("pulse_without_expectation", {30'd0, frame_done_o, abort_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_abort", abort_o, e.is_abort);
                check("pulse_kind_done", frame_done_o, !e.is_abort);
                check("pulse_frame_id", frame_id_o, e.id);
                if (!e.is_abort) begin
                    check("deser_word_ready", drdy, 1'b1);
                    check("deser_word", dword, e.word);
                end
            end
        end
        drdy = 1'b0;
        if (deser_srst_o) begin
            dsr  = '0;
            dcnt = 0;
        end else if (ser_data_val_o) begin
            dsr = {dsr[14:0], ser_data_o};
            if (dcnt == FLEN - 1) begin
                dword = dsr;
                drdy  = 1'b1;
                dcnt  = 0;
            end else begin
                dcnt++;
            end
        end
    end

    // One cycle of source activity; non-granted lanes carry random noise.
    task automatic drive_cycle(input int s, input bit v, input bit b);
        logic [N-1:0] m;
        m          = N'(1) << s;
        data_val_i = (N'($urandom) & ~m) | (v ? m : '0);
        data_i     = (N'($urandom) & ~m) | (b ? m : '0);
        #1;
        check("mux_val", ser_data_val_o, v);
        if (v) check("mux_data", ser_data_o, b);
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_grant(input logic [N-1:0] req_seen, output int s);
        s      = rr_pick(m_last, req_seen);
        m_last = s;
        check("grant", gnt_o, 32'(1 << s));
        check("grant_id", frame_id_o, s);
    endtask

    // Drives one frame on granted source s; abort_at>=0 stalls before that bit until timeout.
    task automatic send_frame(input int s, input logic [15:0] word, input int abort_at,
                              input int last_stall, input logic [N-1:0] req_after);
        exp_t e;
        int   stall;
        for (int i = 0; i < FLEN; i++) begin
            if (i == abort_at) begin
                e.is_abort = 1'b1;
                e.id       = s;
                e.word     = '0;
                exp_q.push_back(e);
                req_i = req_after;
                repeat (TIMEOUT) drive_cycle(s, 1'b0, 1'b0);
                check("abort_pulse", abort_o, 1'b1);
                check("abort_flush", deser_srst_o, 1'b1);
                check("abort_gnt_low", gnt_o, '0);
                check("abort_no_done", frame_done_o, 1'b0);
                return;
            end
            stall = (i == FLEN - 1 && last_stall >= 0) ? last_stall : int'($urandom_range(0, 3));
            repeat (stall) drive_cycle(s, 1'b0, 1'b0);
            if (i == FLEN - 1) begin
                e.is_abort = 1'b0;
                e.id       = s;
                e.word     = word;
                exp_q.push_back(e);
                req_i = req_after;
            end
            drive_cycle(s, 1'b1, word[FLEN-1-i]);
        end
        check("done_pulse", frame_done_o, 1'b1);
        check("done_no_abort", abort_o, 1'b0);
        check("done_gnt_low", gnt_o, '0);
        check("done_id_held", frame_id_o, s);
    endtask

    // Cycle after done/abort: flush has ended, and a waiting request is granted now.
    task automatic advance(input logic [N-1:0] req_after, output int s);
        @(posedge clk_i);
        #1;
        check("flush_one_cycle", deser_srst_o, 1'b0);
        s = -1;
        if (req_after != '0) expect_grant(req_after, s);
        else check("idle_gnt_low", gnt_o, '0);
    endtask

    task automatic start_from_idle(input logic [N-1:0] req, output int s);
        req_i = req;
        @(posedge clk_i);
        #1;
        expect_grant(req, s);
    endtask

    task automatic do_reset();
        srst_i = 1'b1;
        req_i  = '0;
        @(posedge clk_i);
        #1;
        check("rst_gnt", gnt_o, '0);
        check("rst_id", frame_id_o, '0);
        check("rst_done", frame_done_o, 1'b0);
        check("rst_abort", abort_o, 1'b0);
        check("rst_deser_srst", deser_srst_o, 1'b1);
        check("rst_ser_val", ser_data_val_o, 1'b0);
        srst_i = 1'b0;
        m_last = N - 1;
    endtask

    initial begin
        int           s;
        int           ab;
        int           ls;
        logic [N-1:0] ra;
        srst_i     = 1'b1;
        req_i      = '0;
        data_i     = '0;
        data_val_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        do_reset();

        // Single frame from source 0.
        start_from_idle(4'b0001, s);
        send_frame(s, 16'hA5C3, -1, -1, '0);
        advance('0, s);

        // All sources requesting: 0,1,2,3,0 with one idle cycle between grants.
        do_reset();
        start_from_idle(4'b1111, s);
        for (int f = 0; f < 5; f++) begin
            ra = (f == 4) ? '0 : 4'b1111;
            send_frame(s, 16'($urandom), -1, -1, ra);
            advance(ra, s);
        end

        // last=1, then 0110 gives 2 then 1.
        do_reset();
        start_from_idle(4'b0010, s);
        send_frame(s, 16'($urandom), -1, -1, 4'b0110);
        advance(4'b0110, s);
        send_frame(s, 16'($urandom), -1, -1, 4'b0110);
        advance(4'b0110, s);
        send_frame(s, 16'($urandom), -1, -1, '0);
        advance('0, s);

        // Source 1 aborts after 5 bits; RR moves past it to source 2.
        do_reset();
        start_from_idle(4'b0010, s);
        send_frame(s, 16'($urandom), 5, -1, 4'b0110);
        advance(4'b0110, s);
        send_frame(s, 16'($urandom), -1, -1, '0);
        advance('0, s);

        // Final bit lands on the last stall cycle before timeout.
        start_from_idle(4'b1000, s);
        send_frame(s, 16'h3C5A, -1, TIMEOUT - 1, '0);
        advance('0, s);

        // Reset mid-frame, then source 3 alone after release.
        do_reset();
        start_from_idle(4'b0001, s);
        req_i = '0;
        for (int i = 0; i < 8; i++) drive_cycle(s, 1'b1, 1'($urandom));
        srst_i = 1'b1;
        #1;
        check("midframe_srst_pass", deser_srst_o, 1'b1);
        @(posedge clk_i);
        #1;
        check("midframe_gnt_low", gnt_o, '0);
        check("midframe_no_done", frame_done_o, 1'b0);
        check("midframe_no_abort", abort_o, 1'b0);
        srst_i = 1'b0;
        m_last = N - 1;
        start_from_idle(4'b1000, s);
        send_frame(s, 16'($urandom), -1, -1, '0);
        advance('0, s);

        // Randomized frames, mixing back-to-back grants, aborts and boundary stalls.
        start_from_idle(rand_req(), s);
        for (int f = 0; f < 40; f++) begin
            ra = (f == 39 || $urandom_range(0, 2) == 0) ? '0 : rand_req();
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, FLEN - 1)) : -1;
            ls = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : -1;
            send_frame(s, 16'($urandom), ab, ls, ra);
            advance(ra, s);
            if (ra == '0 && f != 39) start_from_idle(rand_req(), s);
        end

        repeat (3) @(posedge clk_i);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
